// File: rtl/div_unit_pkg.sv
// div_unit_pkg: divider FSM encodings, handshake levels, aluop codes and EX-side helpers
package div_unit_pkg;
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;
    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;

    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;
    localparam logic [7:0] EXE_REM_OP  = 8'b0001_1100;
    localparam logic [7:0] EXE_REMU_OP = 8'b0001_1101;

    localparam logic [2:0] EXE_RES_DIV = 3'b101;
    localparam logic [2:0] EXE_RES_REM = 3'b110;

    localparam int DoubleRegBus = 64;
    typedef logic [DoubleRegBus-1:0] double_reg_t;

    // EX holds the pipeline until the divider hands back its result
    function automatic logic ex_div_stall(input logic start, input logic ready);
        return start & ~ready;
    endfunction

    function automatic logic [31:0] ex_div_result(input logic [7:0] aluop, input double_reg_t res);
        return (aluop == EXE_REM_OP || aluop == EXE_REMU_OP) ? res[63:32] : res[31:0];
    endfunction
endpackage

// File: rtl/div_unit.sv
// div_unit: 32-step restoring divider for RV32M DIV/DIVU/REM/REMU,
// returns {remainder, quotient} with a level start / ready handshake.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                signed_div_i,
    input  logic [DATA_W-1:0]   opdata1_i,
    input  logic [DATA_W-1:0]   opdata2_i,
    input  logic                start_i,
    input  logic                annul_i,
    output logic [2*DATA_W-1:0] result_o,
    output logic                ready_o
);
    localparam int W = DATA_W;

    div_state_e       state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [2*W:0]     dividend, dividend_step;
    logic [W:0]       diff;
    logic [W-1:0]     divisor, op1_raw, mag1, mag2, quot, rem;
    logic             sgn_mode, sgn1, sgn2, ready_d;
    logic [2*W-1:0]   result_d;

    always_comb begin
        mag1 = signed_div_i && opdata1_i[W-1] ? -opdata1_i : opdata1_i;
        mag2 = signed_div_i && opdata2_i[W-1] ? -opdata2_i : opdata2_i;
        diff = {1'b0, dividend[2*W-1:W]} - {1'b0, divisor};
        dividend_step = diff[W] ? {dividend[2*W-1:0], 1'b0} : {diff[W-1:0], dividend[W-1:0], 1'b1};
        // magnitude results are fixed up using the latched operand signs
        quot = sgn_mode && (sgn1 ^ sgn2) ? -dividend_step[W-1:0] : dividend_step[W-1:0];
        rem = sgn_mode && sgn1 ? -dividend_step[2*W:W+1] : dividend_step[2*W:W+1];
        state_d = state;
        ready_d = DivResultNotReady;
        result_d = '0;
        if (annul_i) begin
            state_d = DivFree;
        end else begin
            case (state)
                DivFree: begin
                    if (start_i == DivStart) state_d = opdata2_i == '0 ? DivByZero : DivOn;
                end
                DivByZero: begin
                    state_d = DivEnd;
                    ready_d = DivResultReady;
                    result_d = {op1_raw, {W{1'b1}}};
                end
                DivOn: begin
                    if (cnt == CNT_W'(W - 1)) begin
                        state_d = DivEnd;
                        ready_d = DivResultReady;
                        result_d = {rem, quot};
                    end
                end
                DivEnd: begin
                    state_d = start_i ? DivEnd : DivFree;
                    ready_d = start_i ? DivResultReady : DivResultNotReady;
                    result_d = start_i ? result_o : '0;
                end
                default: state_d = DivFree;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DivFree;
            result_o <= '0;
            ready_o <= DivResultNotReady;
            cnt <= '0;
        end else begin
            state <= state_d;
            result_o <= result_d;
            ready_o <= ready_d;
            if (state == DivFree) begin
                cnt <= '0;
                op1_raw <= opdata1_i;
                sgn_mode <= signed_div_i;
                sgn1 <= opdata1_i[W-1];
                sgn2 <= opdata2_i[W-1];
                divisor <= mag2;
                dividend <= {{W{1'b0}}, mag1, 1'b0};
            end else if (state == DivOn) begin
                dividend <= dividend_step;
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed checks of div_unit latency, results, annul, reset and hold behaviour
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div = 1'b0;
    logic [31:0] opdata1 = '0;
    logic [31:0] opdata2 = '0;
    logic        start = 1'b0;
    logic        annul = 1'b0;
    logic [63:0] result;
    logic        ready;

    int   total = 0;
    int   bad = 0;
    logic busy = 1'b0;
    logic [31:0] cur_a = '0, cur_b = '0;
    logic        cur_s = 1'b0;

    div_unit dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div), .opdata1_i(opdata1),
        .opdata2_i(opdata2), .start_i(start), .annul_i(annul),
        .result_o(result), .ready_o(ready)
    );

    always #5 clk = ~clk;

    // RISC-V division semantics in plain arithmetic: {remainder, quotient}
    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ready) begin
                chk("model", result, model(cur_a, cur_b, cur_s));
                chk("ready_without_request", 64'(busy), 64'd1);
            end else begin
                chk("result_zero_when_not_ready", result, 64'd0);
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // counts from the cycle in which IDLE samples start (cycle 0)
    task automatic wait_ready(input int lat, input logic [63:0] exp);
        int  k = 0;
        bit  got = 0;
        while (k < 60 && !got) begin
            cycle();
            k++;
            if (k == 1) begin
                opdata1 = $urandom;
                opdata2 = $urandom;
                signed_div = ~signed_div;
            end
            got = ready;
        end
        chk("latency", 64'(k), 64'(lat));
        chk("result", result, exp);
    endtask

    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        cur_a = a;
        cur_b = b;
        cur_s = s;
        opdata1 = a;
        opdata2 = b;
        signed_div = s;
        busy = 1'b1;
        start = 1'b1;
    endtask

    task automatic drop_start();
        start = 1'b0;
        cycle();
        chk("ready_cleared", 64'(ready), 64'd0);
        chk("result_cleared", result, 64'd0);
        busy = 1'b0;
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input int lat, input logic [63:0] exp, input int hold);
        set_op(a, b, s);
        wait_ready(lat, exp);
        for (int i = 0; i < hold; i++) begin
            cycle();
            chk("hold_ready", 64'(ready), 64'd1);
            chk("hold_result", result, exp);
        end
        drop_start();
    endtask

    initial begin
        logic [31:0] ra, rb;
        chk("model_pin_100_7", model(32'd100, 32'd7, 1'b0), 64'h00000002_0000000E);
        chk("model_pin_m7_2", model(32'hFFFF_FFF9, 32'd2, 1'b1), 64'hFFFFFFFF_FFFFFFFD);
        chk("model_pin_ovf", model(32'h8000_0000, 32'hFFFF_FFFF, 1'b1), 64'h00000000_80000000);
        chk("helper_rem_sel", 64'(ex_div_result(EXE_REM_OP, 64'h00000002_0000000E)), 64'h2);
        chk("helper_div_sel", 64'(ex_div_result(EXE_DIV_OP, 64'h00000002_0000000E)), 64'hE);
        cycle();
        cycle();
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_result", result, 64'd0);
        rst = 1'b0;
        cycle();

        do_op(32'd100, 32'd7, 1'b0, 33, 64'h00000002_0000000E, 0);
        do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 33, 64'hFFFFFFFF_FFFFFFFD, 0);
        do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 33, 64'h00000001_FFFFFFFD, 0);
        do_op(32'd5, 32'd0, 1'b1, 2, 64'h00000005_FFFFFFFF, 0);
        do_op(32'hDEAD_BEEF, 32'd0, 1'b0, 2, 64'hDEADBEEF_FFFFFFFF, 0);
        do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 33, 64'h00000000_80000000, 0);
        do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 33, 64'h00000000_FFFFFFFF, 0);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 64'h00000001_00000001, 0);
        do_op(32'hFFFF_FF9C, 32'd7, 1'b1, 33, 64'hFFFFFFFE_FFFFFFF2, 5);

        // annul at cycle 10 of a 100/7 operation
        set_op(32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 10; i++) cycle();
        annul = 1'b1;
        start = 1'b0;
        busy = 1'b0;
        cycle();
        annul = 1'b0;
        chk("annul_state", 64'(dut.state), 64'(DivFree));
        chk("annul_ready", 64'(ready), 64'd0);
        for (int i = 0; i < 40; i++) cycle();
        do_op(32'd9, 32'd3, 1'b0, 33, 64'h00000000_00000003, 0);

        // simultaneous start and annul is ignored
        opdata1 = 32'd9;
        opdata2 = 32'd3;
        start = 1'b1;
        annul = 1'b1;
        cycle();
        start = 1'b0;
        annul = 1'b0;
        chk("start_annul_state", 64'(dut.state), 64'(DivFree));
        for (int i = 0; i < 40; i++) cycle();

        // reset at cycle 15 with start held through it
        set_op(32'd100, 32'd7, 1'b0);
        for (int i = 0; i < 15; i++) cycle();
        rst = 1'b1;
        cycle();
        chk("midop_reset_ready", 64'(ready), 64'd0);
        chk("midop_reset_result", result, 64'd0);
        chk("midop_reset_state", 64'(dut.state), 64'(DivFree));
        opdata1 = 32'd100;
        opdata2 = 32'd7;
        signed_div = 1'b0;
        rst = 1'b0;
        wait_ready(33, 64'h00000002_0000000E);
        drop_start();

        for (int i = 0; i < 4; i++) begin
            ra = $urandom;
            rb = (i == 3) ? 32'd0 : $urandom >> (i * 8);
            do_op(ra, rb, i[0], rb == 0 ? 2 : 33, model(ra, rb, i[0]), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
Multi-cycle iterative divider implementing RV32M DIV/DIVU/REM/REMU for the execute stage. The EX stage acts as initiator: it holds start_i and asserts stallreq while the operation is busy. div_unit is the responder: it runs a 32-iteration restoring division on operand magnitudes and returns {remainder, quotient} with a ready_o handshake. The result feeds the EX result mux, which selects the quotient or remainder half.

Parameters:
DATA_W, 32, operand width; the iteration count equals DATA_W.
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, synchronous, active-high
signed_div_i  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
opdata1_i  in  DATA_W  dividend
opdata2_i  in  DATA_W  divisor
start_i  in  1  level request from EX, held until ready_o is seen
annul_i  in  1  abort the current operation (flush)
result_o  out  2*DATA_W  {remainder[63:32], quotient[31:0]}, registered
ready_o  out  1  result valid, registered

Behaviour:
- Reset: synchronous. On rst=1 at a clock edge: state<=IDLE, result_o<=0, ready_o<=0, counter<=0. Reset takes effect mid-operation with no output glitch beyond zeroing.
- FSM states: IDLE, BYZERO, ON, END.
- IDLE: ready_o=0, result_o=0.
  - If start_i=1 and annul_i=0 and opdata2_i==0: go to BYZERO.
  - If start_i=1 and annul_i=0 and opdata2_i!=0: go to ON. Latch the following:
    - the magnitude of each operand; in signed mode a negative operand is replaced by its two's-complement;
    - the original sign bits and signed_div_i;
    - the dividend register <= {zeros, |dividend|, 1'b0};
    - counter <= 0.
  - Otherwise stay in IDLE.
- BYZERO: one cycle, then END. The result is quotient = all ones and remainder = the original opdata1_i (RISC-V semantics; no trap).
- ON: one restoring step per cycle.
  - Compute upper-half minus divisor magnitude.
  - If non-negative, shift in the difference and set bit 1; otherwise shift and set bit 0.
  - counter increments each step.
  - After the step with counter == DATA_W-1, go to END and form the final result.
- Sign fix-up (signed mode only):
  - Quotient is negated iff the operand signs differ.
  - Remainder is negated iff the dividend is negative.
  - Overflow case 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 and remainder 0. The magnitude arithmetic produces this naturally; no special case is needed.
- END: ready_o=1 and result_o holds the stable value.
  - Stay in END while start_i=1.
  - When start_i=0: go to IDLE, and ready_o, result_o <= 0 at that edge.
- Latency, with the cycle where IDLE samples start_i counted as 0:
  - Normal operation: ready_o is first high at cycle 33.
  - Divide by zero: ready_o is first high at cycle 2.
- annul_i=1 in any state: go to IDLE next cycle with ready_o=0 and result_o=0. annul_i has priority over start_i, so a simultaneous start and annul is ignored.
- Operands are sampled only in IDLE. Changes on opdata*_i during ON have no effect.
- ready_o is never asserted without a preceding start_i. A new operation cannot begin until the FSM has returned to IDLE, so there is at least one idle cycle between operations.

Decomposition:
- Shared defines file gets:
  - FSM encodings DivFree, DivByZero, DivOn, DivEnd (2 bits);
  - DivStart/DivStop and DivResultReady/DivResultNotReady;
  - new aluop codes EXE_DIV_OP, EXE_DIVU_OP, EXE_REM_OP, EXE_REMU_OP;
  - result selectors EXE_RES_DIV and EXE_RES_REM;
  - DoubleRegBus, which is reused for result_o.
- No sub-module. The subtract-and-shift step and the sign fix-up are small enough to stay inline in a single module.
- EX-side additions: stallreq = start && !ready_o; selection of result_o[31:0] vs result_o[63:32] by aluop.

Test Plan:
- Unsigned 100/7, start held → ready_o at cycle 33 with result_o = {0x00000002, 0x0000000E}; after start_i drops, ready_o=0 and result_o=0 the next cycle.
- Signed −7/2 (0xFFFFFFF9, 0x00000002) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7/−2 → quotient 0xFFFFFFFD, remainder 0x00000001.
- Divide by zero, signed 5/0 → ready_o at cycle 2 with quotient 0xFFFFFFFF and remainder 0x00000005; unsigned 0xDEADBEEF/0 → remainder 0xDEADBEEF.
- Signed overflow 0x80000000/0xFFFFFFFF → quotient 0x80000000, remainder 0, at cycle 33; unsigned 0xFFFFFFFF/1 → quotient 0xFFFFFFFF, remainder 0.
- annul_i pulsed at cycle 10 of a 100/7 operation → ready_o never rises and the FSM is in IDLE at cycle 11; a following 9/3 request completes with quotient 3, remainder 0 at its own cycle 33.
- rst asserted at cycle 15 mid-operation → outputs 0 next cycle; start_i held through reset and beyond restarts cleanly with correct results; start_i held 5 cycles past ready_o → result_o and ready_o remain stable throughout.
